// File: rtl/organ_pkg.sv
// organ_pkg: mixer mode encodings and the default 8-voice pitch table
package organ_pkg;

    localparam logic [1:0] MODE_OR  = 2'd0;
    localparam logic [1:0] MODE_XOR = 2'd1;
    localparam logic [1:0] MODE_AND = 2'd2;
    localparam logic [1:0] MODE_SUM = 2'd3;

    localparam int DEF_VOICES  = 8;
    localparam int DEF_PITCH_W = 16;

    // Half-periods in clocks; voice 0 sits in the least significant slot.
    localparam logic [DEF_VOICES*DEF_PITCH_W-1:0] DEF_PITCHES = {
        16'd7645, 16'd8099, 16'd9091, 16'd10204,
        16'd11454, 16'd12135, 16'd13621, 16'd15289
    };

endpackage

// File: rtl/organ_voice.sv
// organ_voice: one square-wave oscillator with key synchroniser, release sustain and gate
module organ_voice
    import organ_pkg::*;
#(
    parameter int                 PITCH_W        = 16,
    parameter logic [PITCH_W-1:0] PITCH          = '0,
    parameter int                 SUSTAIN_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic sq_o,
    output logic gate_o
);

    localparam int                 SW   = SUSTAIN_CYCLES > 0 ? $clog2(SUSTAIN_CYCLES + 1) : 1;
    localparam logic [PITCH_W-1:0] LAST = PITCH - 1'b1;

    logic [PITCH_W-1:0] cnt_q, cnt_d;
    logic               sq_q, sq_d;
    logic               s1_q, s2_q;
    logic               prs_q;
    logic [SW-1:0]      sus_q, sus_d;
    logic               gate_q, gate_d;
    logic               pressed, rel;

    // Oscillator: wrap at PITCH-1 and toggle; a zero pitch parks everything at 0
    always_comb begin
        cnt_d = (PITCH == '0 || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        sq_d  = (PITCH == '0) ? 1'b0 : sq_q ^ (cnt_q == LAST);
    end

    // Sustain and gate: the release cycle itself holds the gate so it never blinks low
    always_comb begin
        pressed = ~s2_q;
        rel     = prs_q & ~pressed;
        sus_d   = pressed ? '0 : rel ? SW'(SUSTAIN_CYCLES) : (sus_q != '0) ? sus_q - 1'b1 : sus_q;
        gate_d  = pressed | (sus_q != '0) | (rel && SUSTAIN_CYCLES != 0);
    end

    // State registers, including the 2-FF key synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sq_q   <= 1'b0;
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prs_q  <= 1'b0;
            sus_q  <= '0;
            gate_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sq_q   <= sq_d;
            s1_q   <= btn_n_i;
            s2_q   <= s1_q;
            prs_q  <= pressed;
            sus_q  <= sus_d;
            gate_q <= gate_d;
        end
    end

    assign sq_o   = sq_q;
    assign gate_o = gate_q;

endmodule

// File: rtl/poly_organ.sv
// poly_organ: NUM_VOICES square-wave voices combined by a selectable OR/XOR/AND/PWM-sum mixer
module poly_organ
    import organ_pkg::*;
#(
    parameter int                                NUM_VOICES     = 8,
    parameter int                                PITCH_W        = 16,
    parameter logic [NUM_VOICES*PITCH_W-1:0]     PITCHES        = DEF_PITCHES,
    parameter int                                SUSTAIN_CYCLES = 1200000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_VOICES-1:0] btn_n,
    input  logic [1:0]            mode,
    output logic                  pwmout,
    output logic [NUM_VOICES-1:0] led
);

    localparam int LW = $clog2(NUM_VOICES + 1);
    localparam int PW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;

    logic [NUM_VOICES-1:0] sq, gate, v;
    logic [LW-1:0]         level, lvl_q, lvl_d;
    logic [PW-1:0]         pwm_cnt_q, pwm_cnt_d;
    logic                  pwm_q, pwm_d;
    logic                  frame_end;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        organ_voice #(
            .PITCH_W       (PITCH_W),
            .PITCH         (PITCHES[i*PITCH_W +: PITCH_W]),
            .SUSTAIN_CYCLES(SUSTAIN_CYCLES)
        ) u_voice (
            .clk    (clk),
            .rst    (rst),
            .btn_n_i(btn_n[i]),
            .sq_o   (sq[i]),
            .gate_o (gate[i])
        );
    end

    assign v   = sq & gate;
    assign led = gate;

    // Number of voices currently high, feeding the PWM frame latch
    always_comb begin
        level = '0;
        for (int k = 0; k < NUM_VOICES; k++) level = level + LW'(v[k]);
    end

    // Mixer and PWM frame: AND only considers gated voices; SUM compares slot index to latched level
    always_comb begin
        frame_end = pwm_cnt_q == PW'(NUM_VOICES - 1);
        pwm_cnt_d = frame_end ? '0 : pwm_cnt_q + 1'b1;
        lvl_d     = frame_end ? level : lvl_q;
        pwm_d     = mode == MODE_OR  ? |v :
                    mode == MODE_XOR ? ^v :
                    mode == MODE_AND ? (|gate) & (&(v | ~gate)) :
                                       LW'(pwm_cnt_q) < lvl_q;
    end

    // Mixer registers; the PWM frame counter runs regardless of mode
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            lvl_q     <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            lvl_q     <= lvl_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwmout = pwm_q;

endmodule

// File: tb/tb_poly_organ.sv
// tb_poly_organ: scoreboard bench; stimulus queues per-cycle expectations, a negedge monitor checks them
module tb_poly_organ;
    import organ_pkg::*;

    localparam int R0 = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1, rst_b = 1'b1;
    logic [2:0] btn = 3'b111, btn_b = 3'b111;
    logic [1:0] mode = MODE_OR, mode_b = MODE_OR;
    logic       pw_a, pw_b;
    logic [2:0] led_a, led_b;

    always #5 clk = ~clk;

    poly_organ #(.NUM_VOICES(3), .PITCH_W(4), .PITCHES(12'h654), .SUSTAIN_CYCLES(10)) dut_a (
        .clk(clk), .rst(rst), .btn_n(btn), .mode(mode), .pwmout(pw_a), .led(led_a)
    );

    poly_organ #(.NUM_VOICES(3), .PITCH_W(4), .PITCHES(12'h054), .SUSTAIN_CYCLES(10)) dut_b (
        .clk(clk), .rst(rst_b), .btn_n(btn_b), .mode(mode_b), .pwmout(pw_b), .led(led_b)
    );

    typedef struct {
        int         c;
        int         ph;
        logic [2:0] led;
        logic       pw;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic sqm(int c, int p);
        if (p == 0 || c < R0) return 1'b0;
        return ((c - R0) / p) % 2 == 1;
    endfunction

    function automatic int pc(int c);
        return (c - R0) % 3;
    endfunction

    task automatic push_a(int c, int ph, logic [2:0] l, logic p);
        qa.push_back('{c, ph, l, p});
    endtask

    task automatic push_b(int c, int ph, logic [2:0] l, logic p);
        qb.push_back('{c, ph, l, p});
    endtask

    task automatic wait_to(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk(string nm, exp_t e, logic [2:0] gl, logic gp);
        checks += 2;
        if (gl !== e.led) begin
            errors++;
            $display("FAIL %s_led ph%0d cyc%0d got %b want %b", nm, e.ph, e.c, gl, e.led);
        end
        if (gp !== e.pw) begin
            errors++;
            $display("FAIL %s_pwmout ph%0d cyc%0d got %b want %b", nm, e.ph, e.c, gp, e.pw);
        end
    endtask

    exp_t ea, eb;

    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].c <= cyc) begin
            ea = qa.pop_front();
            if (ea.c < cyc) begin
                checks++;
                errors++;
                $display("FAIL a_missed ph%0d cyc%0d now %0d", ea.ph, ea.c, cyc);
            end else chk("a", ea, led_a, pw_a);
        end
        while (qb.size() > 0 && qb[0].c <= cyc) begin
            eb = qb.pop_front();
            if (eb.c < cyc) begin
                checks++;
                errors++;
                $display("FAIL b_missed ph%0d cyc%0d now %0d", eb.ph, eb.c, cyc);
            end else chk("b", eb, led_b, pw_b);
        end
    end

    int         pa[3] = '{4, 5, 6};
    int         lvl, vp;
    logic [2:0] g;
    logic       p;

    initial begin
        // reset held for two edges, outputs quiet for 20 cycles after
        for (int c = 1; c <= 22; c++) begin
            push_a(c, 1, 3'b000, 1'b0);
            push_b(c, 1, 3'b000, 1'b0);
        end
        wait_to(2);
        rst = 1'b0;
        rst_b = 1'b0;

        // OR mode, key 0 pressed: gate at +3, voice on pwmout from +4
        wait_to(24);
        btn = 3'b110;
        for (int c = 25; c <= 67; c++) push_a(c, 2, c >= 27 ? 3'b001 : 3'b000, c >= 28 ? sqm(c - 1, 4) : 1'b0);
        wait_to(67);
        btn = 3'b111;
        for (int c = 68; c <= 87; c++) push_a(c, 3, c <= 80 ? 3'b001 : 3'b000, c <= 81 ? sqm(c - 1, 4) : 1'b0);

        // press, release, re-press mid-sustain: gate never drops
        wait_to(87);
        btn = 3'b110;
        for (int c = 88; c <= 107; c++) push_a(c, 3, c >= 90 ? 3'b001 : 3'b000, c >= 91 ? sqm(c - 1, 4) : 1'b0);
        wait_to(107);
        btn = 3'b111;
        for (int c = 108; c <= 147; c++) push_a(c, 3, 3'b001, sqm(c - 1, 4));
        wait_to(113);
        btn = 3'b110;
        wait_to(147);
        btn = 3'b111;
        for (int c = 148; c <= 170; c++) push_a(c, 3, c <= 160 ? 3'b001 : 3'b000, c <= 161 ? sqm(c - 1, 4) : 1'b0);

        // XOR with keys 0 and 1
        wait_to(170);
        mode = MODE_XOR;
        btn = 3'b100;
        for (int c = 171; c <= 253; c++)
            push_a(c, 4, c >= 173 ? 3'b011 : 3'b000, c >= 174 ? sqm(c - 1, 4) ^ sqm(c - 1, 5) : 1'b0);

        // AND while keys 0,1 sustain, then AND with nothing gated
        wait_to(253);
        mode = MODE_AND;
        btn = 3'b111;
        for (int c = 254; c <= 288; c++)
            push_a(c, 4, c <= 266 ? 3'b011 : 3'b000, c <= 267 ? sqm(c - 1, 4) & sqm(c - 1, 5) : 1'b0);

        // SUM with all keys: level latched at frame end, PWM'd over the next frame
        wait_to(288);
        mode = MODE_SUM;
        btn = 3'b000;
        lvl = 0;
        for (int e = 289; e <= 418; e++) begin
            g = (e - 1 >= 291) ? 3'b111 : 3'b000;
            vp = 0;
            for (int i = 0; i < 3; i++) vp += (sqm(e - 1, pa[i]) & g[i]) ? 1 : 0;
            p = pc(e - 1) < lvl;
            push_a(e, 5, e >= 291 ? 3'b111 : 3'b000, p);
            if (pc(e - 1) == 2) lvl = vp;
        end
        wait_to(418);
        btn = 3'b111;

        // second organ: voice 2 has pitch 0 and stays silent
        wait_to(420);
        btn_b = 3'b011;
        for (int c = 421; c <= 448; c++) push_b(c, 6, c >= 423 ? 3'b100 : 3'b000, 1'b0);
        wait_to(448);
        btn_b = 3'b010;
        for (int c = 449; c <= 468; c++) push_b(c, 6, c >= 451 ? 3'b101 : 3'b100, c >= 452 ? sqm(c - 1, 4) : 1'b0);
        wait_to(468);
        btn_b = 3'b111;
        for (int c = 469; c <= 474; c++) push_b(c, 6, 3'b101, sqm(c - 1, 4));

        // reset during sustain clears on the next edge
        wait_to(474);
        rst_b = 1'b1;
        push_b(475, 7, 3'b000, 1'b0);
        wait_to(475);
        rst_b = 1'b0;
        for (int c = 476; c <= 490; c++) push_b(c, 7, 3'b000, 1'b0);

        wait_to(490);
        while ((qa.size() > 0 || qb.size() > 0) && cyc < 600) @(negedge clk);
        checks++;
        if (qa.size() > 0 || qb.size() > 0) begin
            errors++;
            $display("FAIL drain pending a=%0d b=%0d want 0", qa.size(), qb.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
